// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit carry-lookahead slice, LS nibble first.
// Optional macro ALU_SUB_EN adds the op_sub port and subtract (A + ~B + 1) support.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ALU_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             sub_sel;
  logic [3:0]       slice_s;
  logic             slice_c;

`ifdef ALU_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  nibble_cla4 u_slice (
    .a_i (a_q[4*idx_q +: 4]),
    .b_i (b_q[4*idx_q +: 4]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_sel ? ~b : b;
          carry_d = sub_sel ? 1'b1 : carry_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = slice_s;
        carry_d = slice_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Signed overflow uses the latched (possibly inverted) B.
          cout_d  = slice_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign sum         = sum_q;
  assign carry_out   = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// 4-bit carry-lookahead slice: all carries computed from generate/propagate terms.
module nibble_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
  end

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule
